// File: rtl/roi_shr_driver.sv
// roi_shr_driver: drives a serial din/dout shift-register DUT, applying one stimulus vector and reading back one result per start.
module roi_shr_driver #(
  parameter int DIN_N  = 256,
  parameter int DOUT_N = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIN_N-1:0]  din_vec,
  output logic              busy,
  output logic              done,
  output logic [DOUT_N-1:0] dout_vec,
  output logic              di,
  output logic              stb,
  input  logic              dut_do
);
  localparam int MAXN = DIN_N > DOUT_N ? DIN_N : DOUT_N;
  localparam int CW = MAXN > 1 ? $clog2(MAXN) : 1;
  localparam logic [2:0] IDLE = 3'd0, LOAD1 = 3'd1, APPLY = 3'd2, LOAD2 = 3'd3,
                         CAPTURE = 3'd4, UNLOAD = 3'd5, FIN = 3'd6;
  logic [2:0]        state, nxt;
  logic [CW-1:0]     cnt;
  logic [DIN_N-1:0]  vreg, vnext;
  logic [DOUT_N-1:0] rx, rx_nxt;
  logic              din_last, dout_last, loading;
  assign din_last  = cnt == CW'(DIN_N - 1);
  assign dout_last = cnt == CW'(DOUT_N - 1);
  assign loading   = state == LOAD1 || state == LOAD2;
  assign rx_nxt    = {rx[DOUT_N-2:0], dut_do};
  always_comb begin
    nxt = state == IDLE    ? (start ? LOAD1 : IDLE) :
          state == LOAD1   ? (din_last ? APPLY : LOAD1) :
          state == APPLY   ? LOAD2 :
          state == LOAD2   ? (din_last ? CAPTURE : LOAD2) :
          state == CAPTURE ? UNLOAD :
          state == UNLOAD  ? (dout_last ? FIN : UNLOAD) : IDLE;
    // vreg rotates while loading so it is back to its original value after DIN_N shifts
    vnext = state == IDLE ? (start ? din_vec : vreg) :
            loading ? {vreg[DIN_N-2:0], vreg[DIN_N-1]} : vreg;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      vreg     <= '0;
      rx       <= '0;
      dout_vec <= '0;
      di       <= 1'b0;
      stb      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt != state ? '0 : cnt + 1'b1;
      vreg  <= vnext;
      di    <= (nxt == LOAD1 || nxt == LOAD2) && vnext[DIN_N-1];
      stb   <= nxt == APPLY || nxt == CAPTURE;
      busy  <= nxt != IDLE;
      done  <= nxt == FIN;
      if (state == UNLOAD) rx <= rx_nxt;
      if (state == UNLOAD && dout_last) dout_vec <= rx_nxt;
    end
  end
endmodule

// File: tb/tb_roi_shr_driver.sv
// tb_roi_shr_driver: scoreboard bench with behavioural shift-register DUT models for 8/8 and 8/16 builds.
module tb_roi_shr_driver;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start = 1'b0, busy, done, di, stb, dut_do;
  logic [7:0] din_vec = '0, dout_vec;
  logic start_b = 1'b0, busy_b, done_b, di_b, stb_b, do_b;
  logic [7:0] din_b = '0;
  logic [15:0] dout_b;
  roi_shr_driver #(.DIN_N(8), .DOUT_N(8)) u_a (
    .clk(clk), .rst(rst), .start(start), .din_vec(din_vec), .busy(busy), .done(done),
    .dout_vec(dout_vec), .di(di), .stb(stb), .dut_do(dut_do));
  roi_shr_driver #(.DIN_N(8), .DOUT_N(16)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .din_vec(din_b), .busy(busy_b), .done(done_b),
    .dout_vec(dout_b), .di(di_b), .stb(stb_b), .dut_do(do_b));
  logic [7:0] a_dshr = '0, a_din = '0, a_dout = '0, a_oshr = '0;
  assign dut_do = a_oshr[7];
  always @(posedge clk) begin
    a_dshr <= {a_dshr[6:0], di};
    a_oshr <= stb ? a_dout : {a_oshr[6:0], a_dshr[7]};
    if (stb) a_din <= a_dshr;
    a_dout <= ~a_din;
  end
  logic [7:0] b_dshr = '0, b_din = '0;
  logic [15:0] b_dout = '0, b_oshr = '0;
  assign do_b = b_oshr[15];
  always @(posedge clk) begin
    b_dshr <= {b_dshr[6:0], di_b};
    b_oshr <= stb_b ? b_dout : {b_oshr[14:0], b_dshr[7]};
    if (stb_b) b_din <= b_dshr;
    b_dout <= {b_din, ~b_din};
  end
  int errors = 0, checks = 0, done_cnt = 0;
  logic [7:0] q[$];
  logic [15:0] qb[$];
  always @(posedge clk) if (done) done_cnt++;
  task automatic run_a(input logic [7:0] v, output int lat, output logic [0:40] di_tr, output int stbs);
    logic [7:0] exp;
    @(negedge clk);
    din_vec = v;
    start = 1'b1;
    q.push_back(~v);
    lat = 0;
    stbs = 0;
    di_tr = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      di_tr[i] = di;
      stbs += int'(stb);
      if (done) begin lat = i; break; end
    end
    checks++;
    if (lat != 27) begin errors++; $display("FAIL latency: got %0d want 27", lat); end
    exp = q.pop_front();
    checks++;
    if (dout_vec !== exp) begin errors++; $display("FAIL result: got %h want %h", dout_vec, exp); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (di !== 1'b0) begin errors++; $display("FAIL reset_di: got %b want 0", di); end
    if (stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", stb); end
    if (dout_vec !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout_vec); end
    rst = 1'b0;
  endtask
  task automatic test_basic;
    int lat, stbs;
    logic [0:40] tr;
    run_a(8'hA5, lat, tr, stbs);
    checks += 5;
    if (tr[1:8] !== 8'hA5) begin errors++; $display("FAIL di_load1: got %h want a5", tr[1:8]); end
    if (tr[10:17] !== 8'hA5) begin errors++; $display("FAIL di_load2: got %h want a5", tr[10:17]); end
    if (stbs != 2) begin errors++; $display("FAIL stb_count: got %0d want 2", stbs); end
    if (tr[9] !== 1'b0) begin errors++; $display("FAIL di_apply: got %b want 0", tr[9]); end
    if (tr[18:27] !== 10'd0) begin errors++; $display("FAIL di_unload: got %h want 0", tr[18:27]); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask
  task automatic test_back_to_back;
    int lat, stbs, d0;
    logic [0:40] tr;
    d0 = done_cnt;
    run_a(8'h00, lat, tr, stbs);
    run_a(8'hFF, lat, tr, stbs);
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 2) begin errors++; $display("FAIL done_count: got %0d want 2", done_cnt - d0); end
  endtask
  task automatic test_start_held;
    logic [7:0] exp;
    logic seen;
    @(negedge clk);
    din_vec = 8'h3C;
    start = 1'b1;
    q.push_back(8'hC3);
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      din_vec = 8'($urandom);
    end
    exp = q.pop_front();
    checks += 2;
    if (!seen) begin errors++; $display("FAIL held_timeout: got no done want done"); end
    if (dout_vec !== exp) begin errors++; $display("FAIL held_result1: got %h want %h", dout_vec, exp); end
    din_vec = 8'h96;
    q.push_back(8'h69);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL held_idle: got busy=%b want 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL held_restart: got busy=%b want 1", busy); end
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      start = i[0];
      din_vec = 8'($urandom);
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    exp = q.pop_front();
    checks += 2;
    if (!seen) begin errors++; $display("FAIL held_timeout2: got no done want done"); end
    if (dout_vec !== exp) begin errors++; $display("FAIL held_result2: got %h want %h", dout_vec, exp); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    int lat, stbs, d0;
    logic [0:40] tr;
    @(negedge clk);
    din_vec = 8'h11;
    start = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (dout_vec !== 8'h00) begin errors++; $display("FAIL mid_dout: got %h want 00", dout_vec); end
    if (stb !== 1'b0) begin errors++; $display("FAIL mid_stb: got %b want 0", stb); end
    if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", done); end
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL mid_nodone: got %0d want %0d", done_cnt, d0); end
    run_a(8'h3C, lat, tr, stbs);
  endtask
  task automatic test_wide;
    int lat;
    logic [15:0] exp;
    @(negedge clk);
    din_b = 8'h81;
    start_b = 1'b1;
    qb.push_back(16'h817E);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin lat = i; break; end
    end
    exp = qb.pop_front();
    checks += 2;
    if (lat != 35) begin errors++; $display("FAIL wide_latency: got %0d want 35", lat); end
    if (dout_b !== exp) begin errors++; $display("FAIL wide_result: got %h want %h", dout_b, exp); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
